// File: rtl/cgen_mem_arb_pkg.sv
// Shared helpers and types for the 3-read/1-write memory arbiter.
package cgen_mem_arb_pkg;

    // Widest requester id needed (N_RD is at most 8).
    localparam int unsigned MaxIdW = 3;

    function automatic int unsigned log2_f(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

    function automatic int unsigned id_w_f(input int unsigned n);
        return (n <= 1) ? 1 : log2_f(n);
    endfunction

    typedef struct packed {
        logic              valid;
        logic [MaxIdW-1:0] id;
    } rsp_trk_t;

endpackage

// File: rtl/cgen_rr_pick.sv
// Round-robin picker: first valid, non-skipped index at or after ptr_i, wrapping modulo N.
module cgen_rr_pick
    import cgen_mem_arb_pkg::*;
#(
    parameter int unsigned  N  = 4,
    localparam int unsigned IW = id_w_f(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    input  logic [N-1:0]  skip_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [N-1:0] cand;

    assign cand = valid_i & ~skip_i;

    always_comb begin
        int unsigned j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        // Walk offsets high to low so the candidate closest to ptr_i is written last.
        for (int off = int'(N) - 1; off >= 0; off--) begin
            j = 32'(ptr_i) + 32'(off);
            if (j >= N) j = j - N;
            if (cand[j[IW-1:0]]) begin
                gnt_o             = '0;
                gnt_o[j[IW-1:0]]  = 1'b1;
                idx_o             = j[IW-1:0];
                any_o             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cgen_memory_3rd_1wr_arb.sv
// Arbiter/sequencer in front of the 3-read/1-write memory macro: round-robin write and
// triple-read arbitration, with fixed-latency routing of read data back to its requester.
module cgen_memory_3rd_1wr_arb
    import cgen_mem_arb_pkg::*;
#(
    parameter int unsigned  BITS      = 4,
    parameter int unsigned  SIZE      = 128,
    parameter int unsigned  WENSIZE   = 1,
    parameter int unsigned  LATENCY_0 = 1,
    parameter int unsigned  N_RD      = 4,
    parameter int unsigned  N_WR      = 2,
    localparam int unsigned AW        = log2_f(SIZE)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [N_WR-1:0]         wr_req_valid,
    output logic [N_WR-1:0]         wr_req_ready,
    input  logic [N_WR*AW-1:0]      wr_req_addr,
    input  logic [N_WR*BITS-1:0]    wr_req_data,
    input  logic [N_WR*WENSIZE-1:0] wr_req_mask,
    input  logic [N_RD-1:0]         rd_req_valid,
    output logic [N_RD-1:0]         rd_req_ready,
    input  logic [N_RD*AW-1:0]      rd_req_addr,
    output logic [N_RD-1:0]         rd_rsp_valid,
    output logic [N_RD*BITS-1:0]    rd_rsp_data,
    output logic [AW-1:0]           mem_rd_addr_0,
    output logic [AW-1:0]           mem_rd_addr_1,
    output logic [AW-1:0]           mem_rd_addr_2,
    output logic                    mem_rd_enable_0,
    output logic                    mem_rd_enable_1,
    output logic                    mem_rd_enable_2,
    input  logic [BITS-1:0]         mem_rd_dout_0,
    input  logic [BITS-1:0]         mem_rd_dout_1,
    input  logic [BITS-1:0]         mem_rd_dout_2,
    output logic [AW-1:0]           mem_wr_addr_0,
    output logic [WENSIZE-1:0]      mem_wr_enable_0,
    output logic [BITS-1:0]         mem_wr_din_0
);

    localparam int unsigned RdIw  = id_w_f(N_RD);
    localparam int unsigned WrIw  = id_w_f(N_WR);
    localparam int unsigned RdLat = 1 + LATENCY_0;

    // Write arbitration
    logic [N_WR-1:0] wr_valid_g, wr_gnt;
    logic [WrIw-1:0] wr_ptr_q, wr_ptr_d, wr_idx;
    logic            wr_any;

    // Reset gates the request vectors so no grant or memory enable leaks out during reset.
    assign wr_valid_g = wr_req_valid & {N_WR{reset_n}};

    cgen_rr_pick #(.N(N_WR)) u_wr_pick (
        .valid_i (wr_valid_g),
        .ptr_i   (wr_ptr_q),
        .skip_i  ('0),
        .gnt_o   (wr_gnt),
        .idx_o   (wr_idx),
        .any_o   (wr_any)
    );

    assign wr_req_ready    = wr_gnt;
    assign mem_wr_addr_0   = wr_req_addr[32'(wr_idx)*AW +: AW];
    assign mem_wr_din_0    = wr_req_data[32'(wr_idx)*BITS +: BITS];
    assign mem_wr_enable_0 = wr_any ? wr_req_mask[32'(wr_idx)*WENSIZE +: WENSIZE] : '0;
    assign wr_ptr_d        = !wr_any ? wr_ptr_q :
                             (32'(wr_idx) == N_WR - 1) ? '0 : wr_idx + 1'b1;

    // Read arbitration: three chained picks, each skipping the earlier winners.
    logic [N_RD-1:0] rd_valid_g, rd_gnt0, rd_gnt1, rd_gnt2;
    logic [RdIw-1:0] rd_ptr_q, rd_ptr_d, rd_idx0, rd_idx1, rd_idx2, rd_last;
    logic            rd_any0, rd_any1, rd_any2;

    assign rd_valid_g = rd_req_valid & {N_RD{reset_n}};

    cgen_rr_pick #(.N(N_RD)) u_rd_pick0 (
        .valid_i (rd_valid_g),
        .ptr_i   (rd_ptr_q),
        .skip_i  ('0),
        .gnt_o   (rd_gnt0),
        .idx_o   (rd_idx0),
        .any_o   (rd_any0)
    );

    cgen_rr_pick #(.N(N_RD)) u_rd_pick1 (
        .valid_i (rd_valid_g),
        .ptr_i   (rd_ptr_q),
        .skip_i  (rd_gnt0),
        .gnt_o   (rd_gnt1),
        .idx_o   (rd_idx1),
        .any_o   (rd_any1)
    );

    cgen_rr_pick #(.N(N_RD)) u_rd_pick2 (
        .valid_i (rd_valid_g),
        .ptr_i   (rd_ptr_q),
        .skip_i  (rd_gnt0 | rd_gnt1),
        .gnt_o   (rd_gnt2),
        .idx_o   (rd_idx2),
        .any_o   (rd_any2)
    );

    assign rd_req_ready    = rd_gnt0 | rd_gnt1 | rd_gnt2;
    assign mem_rd_enable_0 = rd_any0;
    assign mem_rd_enable_1 = rd_any1;
    assign mem_rd_enable_2 = rd_any2;
    assign mem_rd_addr_0   = rd_any0 ? rd_req_addr[32'(rd_idx0)*AW +: AW] : '0;
    assign mem_rd_addr_1   = rd_any1 ? rd_req_addr[32'(rd_idx1)*AW +: AW] : '0;
    assign mem_rd_addr_2   = rd_any2 ? rd_req_addr[32'(rd_idx2)*AW +: AW] : '0;

    assign rd_last  = rd_any2 ? rd_idx2 : (rd_any1 ? rd_idx1 : rd_idx0);
    assign rd_ptr_d = !rd_any0 ? rd_ptr_q :
                      (32'(rd_last) == N_RD - 1) ? '0 : rd_last + 1'b1;

    // Response tracking: one {valid, id} shift register per memory read port.
    rsp_trk_t        trk_in  [3];
    rsp_trk_t        trk_q   [3][RdLat];
    logic [BITS-1:0] rd_dout [3];
    logic [N_RD-1:0]      rsp_valid_q, rsp_valid_d;
    logic [N_RD*BITS-1:0] rsp_data_q, rsp_data_d;

    assign trk_in[0]  = '{valid: rd_any0, id: MaxIdW'(rd_idx0)};
    assign trk_in[1]  = '{valid: rd_any1, id: MaxIdW'(rd_idx1)};
    assign trk_in[2]  = '{valid: rd_any2, id: MaxIdW'(rd_idx2)};
    assign rd_dout[0] = mem_rd_dout_0;
    assign rd_dout[1] = mem_rd_dout_1;
    assign rd_dout[2] = mem_rd_dout_2;

    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        for (int k = 0; k < 3; k++) begin
            if (trk_q[k][RdLat-1].valid) begin
                rsp_valid_d[trk_q[k][RdLat-1].id[RdIw-1:0]]           = 1'b1;
                rsp_data_d[32'(trk_q[k][RdLat-1].id)*BITS +: BITS] = rd_dout[k];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            for (int k = 0; k < 3; k++) begin
                for (int s = 0; s < int'(RdLat); s++) trk_q[k][s] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            for (int k = 0; k < 3; k++) begin
                trk_q[k][0] <= trk_in[k];
                for (int s = 1; s < int'(RdLat); s++) trk_q[k][s] <= trk_q[k][s-1];
            end
        end
    end

    assign rd_rsp_valid = rsp_valid_q;
    assign rd_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_cgen_memory_3rd_1wr_arb.sv
// Bench for cgen_memory_3rd_1wr_arb: arbitration vector table, read-response scoreboard,
// a LATENCY_0=0 instance, same-address read/write and mid-flight reset.
`timescale 1ns/1ps
module tb_cgen_memory_3rd_1wr_arb;

    localparam int unsigned AW = 7;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]    wv, wm;
    logic [AW-1:0] wa [2];
    logic [3:0]    wd [2];
    logic [3:0]    rv;
    logic [AW-1:0] ra [4];

    logic [2*AW-1:0] wr_addr_p;
    logic [7:0]      wr_data_p;
    logic [4*AW-1:0] rd_addr_p;
    assign wr_addr_p = {wa[1], wa[0]};
    assign wr_data_p = {wd[1], wd[0]};
    assign rd_addr_p = {ra[3], ra[2], ra[1], ra[0]};

    // DUT A: LATENCY_0 = 1
    logic [1:0]    a_wr_ready;
    logic [3:0]    a_rd_ready, a_rsp_valid;
    logic [15:0]   a_rsp_data;
    logic [AW-1:0] a_ra [3];
    logic [2:0]    a_ren;
    logic [3:0]    a_dout [3];
    logic [AW-1:0] a_waddr;
    logic [0:0]    a_wen;
    logic [3:0]    a_wdin;

    // DUT B: LATENCY_0 = 0, same stimulus
    logic [1:0]    b_wr_ready;
    logic [3:0]    b_rd_ready, b_rsp_valid;
    logic [15:0]   b_rsp_data;
    logic [AW-1:0] b_ra [3];
    logic [2:0]    b_ren;
    logic [3:0]    b_dout [3];
    logic [AW-1:0] b_waddr;
    logic [0:0]    b_wen;
    logic [3:0]    b_wdin;

    cgen_memory_3rd_1wr_arb #(.BITS(4), .SIZE(128), .WENSIZE(1), .LATENCY_0(1),
                              .N_RD(4), .N_WR(2)) u_dut (
        .clock (clock), .reset_n (reset_n),
        .wr_req_valid (wv), .wr_req_ready (a_wr_ready), .wr_req_addr (wr_addr_p),
        .wr_req_data (wr_data_p), .wr_req_mask (wm),
        .rd_req_valid (rv), .rd_req_ready (a_rd_ready), .rd_req_addr (rd_addr_p),
        .rd_rsp_valid (a_rsp_valid), .rd_rsp_data (a_rsp_data),
        .mem_rd_addr_0 (a_ra[0]), .mem_rd_addr_1 (a_ra[1]), .mem_rd_addr_2 (a_ra[2]),
        .mem_rd_enable_0 (a_ren[0]), .mem_rd_enable_1 (a_ren[1]), .mem_rd_enable_2 (a_ren[2]),
        .mem_rd_dout_0 (a_dout[0]), .mem_rd_dout_1 (a_dout[1]), .mem_rd_dout_2 (a_dout[2]),
        .mem_wr_addr_0 (a_waddr), .mem_wr_enable_0 (a_wen), .mem_wr_din_0 (a_wdin)
    );

    cgen_memory_3rd_1wr_arb #(.BITS(4), .SIZE(128), .WENSIZE(1), .LATENCY_0(0),
                              .N_RD(4), .N_WR(2)) u_dut_lat0 (
        .clock (clock), .reset_n (reset_n),
        .wr_req_valid (wv), .wr_req_ready (b_wr_ready), .wr_req_addr (wr_addr_p),
        .wr_req_data (wr_data_p), .wr_req_mask (wm),
        .rd_req_valid (rv), .rd_req_ready (b_rd_ready), .rd_req_addr (rd_addr_p),
        .rd_rsp_valid (b_rsp_valid), .rd_rsp_data (b_rsp_data),
        .mem_rd_addr_0 (b_ra[0]), .mem_rd_addr_1 (b_ra[1]), .mem_rd_addr_2 (b_ra[2]),
        .mem_rd_enable_0 (b_ren[0]), .mem_rd_enable_1 (b_ren[1]), .mem_rd_enable_2 (b_ren[2]),
        .mem_rd_dout_0 (b_dout[0]), .mem_rd_dout_1 (b_dout[1]), .mem_rd_dout_2 (b_dout[2]),
        .mem_wr_addr_0 (b_waddr), .mem_wr_enable_0 (b_wen), .mem_wr_din_0 (b_wdin)
    );

    // Memory model (FWD=0): reads see the pre-write contents; A has 2 read stages, B has 1.
    logic [3:0] mem [128] = '{default: '0};
    logic [3:0] a_s1 [3], a_s2 [3], b_s1 [3];
    always @(posedge clock) begin
        if (a_wen[0]) mem[a_waddr] <= a_wdin;
        for (int k = 0; k < 3; k++) begin
            a_s1[k] <= mem[a_ra[k]];
            a_s2[k] <= a_s1[k];
            b_s1[k] <= mem[b_ra[k]];
        end
    end
    assign a_dout = a_s2;
    assign b_dout = b_s1;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of expected DUT A responses, pushed when the read is driven.
    typedef struct {
        int         due;
        logic [1:0] id;
        logic [3:0] data;
    } exp_t;
    exp_t       sb [$];
    exp_t       mon_e;
    logic [3:0] mon_ev;
    logic [3:0] mon_ed [4];
    bit         mon_en = 1'b0;

    always @(negedge clock) begin
        if (mon_en) begin
            mon_ev = '0;
            while (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e              = sb.pop_front();
                mon_ev[mon_e.id]   = 1'b1;
                mon_ed[mon_e.id]   = mon_e.data;
            end
            check("rsp_valid", 32'(a_rsp_valid), 32'(mon_ev));
            for (int i = 0; i < 4; i++)
                if (mon_ev[i])
                    check($sformatf("rsp_data[%0d]", i), 32'(a_rsp_data[i*4 +: 4]),
                          32'(mon_ed[i]));
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic push_rsp(input int id, input logic [3:0] data);
        sb.push_back('{due: cyc + 3, id: 2'(id), data: data});
    endtask

    typedef struct {
        logic [1:0]    wv;
        logic [AW-1:0] wa0, wa1;
        logic [3:0]    wd0, wd1;
        logic [1:0]    wm;
        logic [3:0]    rv;
        logic [1:0]    e_wr;
        logic          e_wen;
        logic [AW-1:0] e_waddr;
        logic [3:0]    e_wdin;
        logic [3:0]    e_rd;
        logic [AW-1:0] e_pa0;
    } vec_t;
    vec_t vt [11];

    initial begin
        int t;
        int cnt;
        logic [2:0] e_en;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [2:0] e_en;
        int t;
        // Readers 0..3 read addresses 1..4, preloaded by rows 0..3 with data 1..4.
        vt[0]  = '{2'b11, 1, 2, 1, 2, 2'b11, 4'b0000, 2'b01, 1'b1, 1, 1, 4'b0000, 0};
        vt[1]  = '{2'b11, 3, 2, 3, 2, 2'b11, 4'b0000, 2'b10, 1'b1, 2, 2, 4'b0000, 0};
        vt[2]  = '{2'b11, 3, 4, 3, 4, 2'b11, 4'b0000, 2'b01, 1'b1, 3, 3, 4'b0000, 0};
        vt[3]  = '{2'b11, 5, 4, 5, 4, 2'b11, 4'b0000, 2'b10, 1'b1, 4, 4, 4'b0000, 0};
        vt[4]  = '{2'b00, 5, 4, 5, 4, 2'b11, 4'b0000, 2'b00, 1'b0, 0, 0, 4'b0000, 0};
        vt[5]  = '{2'b01, 6, 4, 6, 4, 2'b10, 4'b0000, 2'b01, 1'b0, 6, 6, 4'b0000, 0};
        vt[6]  = '{2'b00, 6, 4, 6, 4, 2'b11, 4'b1111, 2'b00, 1'b0, 0, 0, 4'b0111, 1};
        vt[7]  = '{2'b00, 6, 4, 6, 4, 2'b11, 4'b1111, 2'b00, 1'b0, 0, 0, 4'b1011, 4};
        vt[8]  = '{2'b00, 6, 4, 6, 4, 2'b11, 4'b1111, 2'b00, 1'b0, 0, 0, 4'b1101, 3};
        vt[9]  = '{2'b00, 6, 4, 6, 4, 2'b11, 4'b1111, 2'b00, 1'b0, 0, 0, 4'b1110, 2};
        vt[10] = '{2'b00, 6, 4, 6, 4, 2'b11, 4'b0000, 2'b00, 1'b0, 0, 0, 4'b0000, 0};

        wv = 2'b11; wm = 2'b11; rv = 4'b1111;
        wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
        for (int i = 0; i < 4; i++) ra[i] = AW'(i + 1);

        // Reset with every request valid: nothing may be granted.
        repeat (2) @(negedge clock);
        check("reset wr_ready", 32'(a_wr_ready), 0);
        check("reset rd_ready", 32'(a_rd_ready), 0);
        check("reset wr_enable", 32'(a_wen), 0);
        check("reset rd_enable", 32'(a_ren), 0);
        check("reset rsp_valid", 32'(a_rsp_valid), 0);
        check("reset rsp_data", 32'(a_rsp_data), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        for (int r = 0; r < 11; r++) begin
            wv = vt[r].wv; wm = vt[r].wm; rv = vt[r].rv;
            wa[0] = vt[r].wa0; wa[1] = vt[r].wa1; wd[0] = vt[r].wd0; wd[1] = vt[r].wd1;
            @(negedge clock);
            cnt  = $countones(vt[r].e_rd);
            e_en = (cnt >= 3) ? 3'b111 : (cnt == 2) ? 3'b011 : (cnt == 1) ? 3'b001 : 3'b000;
            check($sformatf("vec%0d wr_ready", r), 32'(a_wr_ready), 32'(vt[r].e_wr));
            check($sformatf("vec%0d wr_enable", r), 32'(a_wen), 32'(vt[r].e_wen));
            if (vt[r].e_wr != 2'b00) begin
                check($sformatf("vec%0d wr_addr", r), 32'(a_waddr), 32'(vt[r].e_waddr));
                check($sformatf("vec%0d wr_din", r), 32'(a_wdin), 32'(vt[r].e_wdin));
            end
            check($sformatf("vec%0d rd_ready", r), 32'(a_rd_ready), 32'(vt[r].e_rd));
            check($sformatf("vec%0d rd_enable", r), 32'(a_ren), 32'(e_en));
            check($sformatf("vec%0d rd_addr0", r), 32'(a_ra[0]), 32'(vt[r].e_pa0));
            for (int i = 0; i < 4; i++)
                if (vt[r].e_rd[i]) push_rsp(i, 4'(i + 1));
            next_cycle();
        end
        repeat (4) next_cycle();

        // Write addr 5 = 0xA, then reader 2 reads it back two cycles later.
        wv = 2'b10; wa[1] = 5; wd[1] = 4'hA;
        @(negedge clock);
        check("wr5 ready", 32'(a_wr_ready), 32'b10);
        next_cycle();
        wv = 2'b00;
        next_cycle();
        rv = 4'b0100; ra[2] = 5;
        @(negedge clock);
        check("rd5 ready", 32'(a_rd_ready), 32'b0100);
        check("rd5 addr0", 32'(a_ra[0]), 5);
        push_rsp(2, 4'hA);
        next_cycle();
        rv = 4'b0000;
        repeat (4) next_cycle();

        // Latency-0 instance: addr 7 = 0x3 returns two cycles after the grant.
        wv = 2'b01; wa[0] = 7; wd[0] = 4'h3;
        @(negedge clock);
        check("wr7 ready", 32'(a_wr_ready), 32'b01);
        next_cycle();
        wv = 2'b00;
        next_cycle();
        rv = 4'b0001; ra[0] = 7;
        @(negedge clock);
        check("rd7 ready", 32'(a_rd_ready), 32'b0001);
        push_rsp(0, 4'h3);
        t = cyc;
        next_cycle();
        rv = 4'b0000;
        @(negedge clock);
        check("lat0 rsp_valid T+1", 32'(b_rsp_valid), 0);
        next_cycle();
        @(negedge clock);
        check("lat0 rsp_valid T+2", 32'(b_rsp_valid), 32'b0001);
        check("lat0 rsp_data T+2", 32'(b_rsp_data[3:0]), 32'h3);
        check("lat0 rsp cycle", 32'(cyc - t), 2);
        next_cycle();
        @(negedge clock);
        check("lat0 rsp_valid T+3", 32'(b_rsp_valid), 0);
        repeat (3) next_cycle();

        // Same-cycle write and read of addr 9: old value first, new value next cycle.
        wv = 2'b01; wa[0] = 9; wd[0] = 4'hF; rv = 4'b0010; ra[1] = 9;
        @(negedge clock);
        check("rw9 wr_ready", 32'(a_wr_ready), 32'b01);
        check("rw9 rd_ready", 32'(a_rd_ready), 32'b0010);
        push_rsp(1, 4'h0);
        next_cycle();
        wv = 2'b00;
        @(negedge clock);
        check("rd9 rd_ready", 32'(a_rd_ready), 32'b0010);
        push_rsp(1, 4'hF);
        next_cycle();
        rv = 4'b0000;
        repeat (4) next_cycle();

        // Two reads in flight, then reset: neither may respond.
        for (int i = 0; i < 4; i++) ra[i] = AW'(i + 1);
        rv = 4'b0001;
        @(negedge clock);
        check("flush rd T", 32'(a_rd_ready), 32'b0001);
        next_cycle();
        @(negedge clock);
        check("flush rd T+1", 32'(a_rd_ready), 32'b0001);
        next_cycle();
        reset_n = 1'b0; rv = 4'b1111; wv = 2'b11;
        @(negedge clock);
        check("mid reset rd_ready", 32'(a_rd_ready), 0);
        check("mid reset wr_ready", 32'(a_wr_ready), 0);
        check("mid reset enables", 32'({a_ren, a_wen}), 0);
        check("mid reset rsp_data", 32'(a_rsp_data), 0);
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        @(negedge clock);
        check("post reset rd_ready", 32'(a_rd_ready), 32'b0111);
        check("post reset wr_ready", 32'(a_wr_ready), 32'b01);
        for (int i = 0; i < 3; i++) push_rsp(i, 4'(i + 1));
        next_cycle();
        rv = 4'b0000; wv = 2'b00;
        repeat (6) next_cycle();
        check("scoreboard drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
